// File: rtl/mux_pkg.sv
// mux_pkg: mode constants shared by the stream mux and its bench
package mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority search from ptr, ptr advances past each accepted grant
module rr_arbiter #(
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);
  logic [SEL_W-1:0] ptr;
  logic [2*N-1:0]   rot;
  int               off;
  always_comb begin
    rot = {req, req} >> ptr;
    off = 0;
    grant_valid = 1'b0;
    for (int o = N - 1; o >= 0; o--) begin
      if (rot[o]) begin
        off = o;
        grant_valid = 1'b1;
      end
    end
    grant = SEL_W'(int'(ptr) + off >= N ? int'(ptr) + off - N : int'(ptr) + off);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (advance && grant_valid) ptr <= grant == SEL_W'(N - 1) ? '0 : grant + 1'b1;
endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-to-1 registered stream mux, fixed or round-robin select; MUX_NX1_STREAM_PARITY_EN adds out_parity
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
`ifdef MUX_NX1_STREAM_PARITY_EN
  output logic               out_parity,
`endif
  input  logic               out_ready
);
  logic             load_en, fix_valid, rr_valid, gnt_valid;
  logic [SEL_W-1:0] rr_grant, gnt;
  logic [WIDTH-1:0] sel_data;
  assign load_en   = !out_valid || out_ready;
  assign gnt       = mode == MODE_RR ? rr_grant : sel;
  assign gnt_valid = !rst && (mode == MODE_RR ? rr_valid : fix_valid);
  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .clk(clk), .rst(rst), .req(in_valid),
    .advance(load_en && mode == MODE_RR && !rst),
    .grant(rr_grant), .grant_valid(rr_valid)
  );
  // out-of-range sel matches no channel, so it grants nothing
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) if (sel == SEL_W'(i)) fix_valid = in_valid[i];
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = load_en && gnt_valid && gnt == SEL_W'(i);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
`ifdef MUX_NX1_STREAM_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (load_en) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= sel_data;
        out_chan <= gnt;
`ifdef MUX_NX1_STREAM_PARITY_EN
        out_parity <= ^sel_data;
`endif
      end
    end
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: directed checks of fixed, round-robin, backpressure, bad sel and reset behaviour
module tb_mux_nx1_stream;
  import mux_pkg::*;
  logic clk = 0, rst = 1;
  logic mode, out_ready, out_valid;
  logic [1:0] sel, out_chan;
  logic [3:0] in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0] out_data;
  logic mode5, out_ready5, out_valid5;
  logic [2:0] sel5, out_chan5;
  logic [4:0] in_valid5, in_ready5;
  logic [39:0] in_data5;
  logic [7:0] out_data5;
`ifdef MUX_NX1_STREAM_PARITY_EN
  logic out_parity, out_parity5;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mux_nx1_stream dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
`ifdef MUX_NX1_STREAM_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready(out_ready)
  );
  mux_nx1_stream #(.WIDTH(8), .N(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5), .out_chan(out_chan5),
`ifdef MUX_NX1_STREAM_PARITY_EN
    .out_parity(out_parity5),
`endif
    .out_ready(out_ready5)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    mode = MODE_RR; sel = 0; in_valid = 4'hF; out_ready = 1;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    mode5 = MODE_SEL; sel5 = 0; in_valid5 = 0; in_data5 = 0; out_ready5 = 1;
    #2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
    total++;
    if (out_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0h exp=0", out_chan); end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    total++;
    step;
    rst = 0;
    mode = MODE_SEL; in_valid = 0;
    step;
  endtask
  task automatic test_fixed;
    mode = MODE_SEL; sel = 2; in_valid = 4'b0100; in_data[16 +: 8] = 8'hA5; out_ready = 1;
    #1;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    total++;
    step;
    in_valid = 0;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid got=%0h exp=1", out_valid); end
    total++;
    if (out_data !== 8'hA5) begin bad++; $display("FAIL fixed_data got=%0h exp=a5", out_data); end
    total++;
    if (out_chan !== 2'd2) begin bad++; $display("FAIL fixed_chan got=%0d exp=2", out_chan); end
    total++;
    step;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h exp=0", out_valid); end
    total++;
  endtask
  task automatic test_rr_sequence;
    logic [1:0] exp_chan [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    mode = MODE_RR; in_valid = 4'hF; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step;
      if (out_chan !== exp_chan[k] || out_valid !== 1'b1 || out_data !== 8'h10 + 8'(exp_chan[k])) begin
        bad++; $display("FAIL rr_seq[%0d] got chan=%0d valid=%0h data=%0h exp chan=%0d", k, out_chan, out_valid, out_data, exp_chan[k]);
      end
      total++;
    end
  endtask
  task automatic test_rr_skip;
    in_valid = 4'b0010;
    step;
    in_valid = 4'b1010;
    #1;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL rr_skip_first got=%b exp=1000", in_ready); end
    total++;
    step;
    if (out_chan !== 2'd3) begin bad++; $display("FAIL rr_skip_chan3 got=%0d exp=3", out_chan); end
    total++;
    if (in_ready !== 4'b0010) begin bad++; $display("FAIL rr_skip_wrap got=%b exp=0010", in_ready); end
    total++;
    step;
    if (out_chan !== 2'd1) begin bad++; $display("FAIL rr_skip_chan1 got=%0d exp=1", out_chan); end
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL rr_skip_ptr2 got=%b exp=1000", in_ready); end
    total++;
  endtask
  task automatic test_backpressure;
    out_ready = 0; in_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      total++;
      if (k == 1) begin mode = MODE_SEL; sel = 0; end
      step;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd1) begin
        bad++; $display("FAIL bp_hold[%0d] got valid=%0h data=%0h chan=%0d exp 1/11/1", k, out_valid, out_data, out_chan);
      end
      total++;
    end
    in_valid = 4'b0001; in_data[7:0] = 8'h3C; out_ready = 1;
    #1;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL bp_replace_ready got=%b exp=0001", in_ready); end
    total++;
    step;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 2'd0) begin
      bad++; $display("FAIL bp_replace got valid=%0h data=%0h chan=%0d exp 1/3c/0", out_valid, out_data, out_chan);
    end
    total++;
    in_valid = 0;
    step;
  endtask
  task automatic test_bad_sel;
    mode5 = MODE_SEL; sel5 = 3'd5; in_valid5 = 5'b11111;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);
    #1;
    if (in_ready5 !== 5'b00000) begin bad++; $display("FAIL bad_sel_ready got=%b exp=00000", in_ready5); end
    total++;
    step;
    if (out_valid5 !== 1'b0) begin bad++; $display("FAIL bad_sel_valid got=%0h exp=0", out_valid5); end
    total++;
    sel5 = 3'd4;
    #1;
    if (in_ready5 !== 5'b10000) begin bad++; $display("FAIL top_sel_ready got=%b exp=10000", in_ready5); end
    total++;
    step;
    if (out_valid5 !== 1'b1 || out_data5 !== 8'h54 || out_chan5 !== 3'd4) begin
      bad++; $display("FAIL top_sel_out got valid=%0h data=%0h chan=%0d exp 1/54/4", out_valid5, out_data5, out_chan5);
    end
    total++;
    in_valid5 = 0;
  endtask
  task automatic test_mid_reset;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    mode = MODE_RR; in_valid = 4'hF; out_ready = 1;
    step;
    step;
    rst = 1;
    #1;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL mid_reset got valid=%0h data=%0h exp 0/00", out_valid, out_data);
    end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0000", in_ready); end
    total++;
    #1;
    rst = 0;
    step;
    if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      bad++; $display("FAIL restart_chan got valid=%0h chan=%0d exp 1/0", out_valid, out_chan);
    end
    total++;
    step;
    if (out_chan !== 2'd1) begin bad++; $display("FAIL restart_next got=%0d exp=1", out_chan); end
    total++;
`ifdef MUX_NX1_STREAM_PARITY_EN
    mode = MODE_SEL; sel = 1; in_valid = 4'b0010; in_data[15:8] = 8'h07;
    step;
    if (out_parity !== 1'b1 || out_data !== 8'h07) begin
      bad++; $display("FAIL parity got par=%0h data=%0h exp 1/07", out_parity, out_data);
    end
    total++;
    in_data[15:8] = 8'h03;
    step;
    if (out_parity !== 1'b0) begin bad++; $display("FAIL parity_even got=%0h exp=0", out_parity); end
    total++;
`endif
  endtask
  initial begin
    test_reset;
    test_fixed;
    test_rr_sequence;
    test_rr_skip;
    test_backpressure;
    test_bad_sel;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_nx1_stream.md
MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel in bits, SHALL be >= 1.
REQ-002 Parameter N, default 4: number of input channels, SHALL be >= 2.
REQ-003 Parameter SEL_W, default $clog2(N): width of the sel and out_chan fields.
REQ-004 Port clk, input, 1: single clock, rising-edge active.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port mode, input, 1: 0 = fixed select (sel), 1 = round-robin.
REQ-007 Port sel, input, SEL_W: channel index used in fixed mode.
REQ-008 Port in_valid, input, N: per-channel valid.
REQ-009 Port in_data, input, N*WIDTH: packed data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port in_ready, output, N: per-channel ready, combinational, at most one bit high.
REQ-011 Port out_valid, output, 1: output register holds data.
REQ-012 Port out_data, output, WIDTH: registered selected data.
REQ-013 Port out_chan, output, SEL_W: index of the channel that supplied out_data.
REQ-014 Port out_ready, input, 1: downstream accepts when out_valid && out_ready.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready); the output register SHALL load only when load_en and a channel is granted.
REQ-016 Fixed mode: grant SHALL be sel when sel < N and in_valid[sel]=1; sel >= N SHALL grant nothing.
REQ-017 Round-robin mode: grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-018 After a round-robin accept from channel k, ptr SHALL become (k+1) mod N; with no accept, ptr SHALL hold; fixed-mode accepts SHALL NOT change ptr.
REQ-019 in_ready[i] SHALL be 1 only when load_en=1 and grant=i; a transfer on channel i is in_valid[i] && in_ready[i].
REQ-020 Latency SHALL be 1 cycle from input transfer to out_valid=1 with that data and out_chan.
REQ-021 Throughput SHALL be one word per cycle while out_ready=1 and a granted channel is valid.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_chan SHALL hold and in_ready SHALL be all zero.
REQ-023 When a downstream accept and a new input accept occur in the same cycle, the register SHALL take the new word and out_valid SHALL stay 1.
REQ-024 When a downstream accept occurs with no grant, out_valid SHALL drop to 0 next cycle.
REQ-025 A mode or sel change SHALL affect only the next selection; a held output word SHALL be unaffected.

Reset
REQ-026 Asserting rst SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=0 (and out_parity=0 when enabled).
REQ-027 A word held in the output register at reset SHALL be discarded.
REQ-028 in_ready SHALL be all zero while rst=1.

Configuration
REQ-029 Macro MUX_NX1_STREAM_PARITY_EN, when defined, SHALL add output port out_parity (1 bit): the registered XOR of the selected word, loaded with out_data.
REQ-030 When the macro is undefined, out_parity SHALL be absent, with no parity logic and no other behaviour change.

Structure
REQ-031 Shared package mux_pkg SHALL hold the mode constants MODE_SEL=1'b0 and MODE_RR=1'b1.
REQ-032 Round-robin search and ptr update SHALL live in sub-module rr_arbiter (parameter N; inputs req and advance; outputs grant index and grant_valid).

Verification
REQ-033 N=4, WIDTH=8, mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2.
REQ-034 mode=1, in_valid=4'b1111 held, out_ready=1, from reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 mode=1, in_valid=4'b1010, ptr=2 -> grant ch3 then ch1; ptr becomes 0 then 2.
REQ-036 Output full, out_ready=0 for 3 cycles -> in_ready=0, out_data stable; out_ready=1 with ch0 valid -> same-cycle replace, out_valid stays 1.
REQ-037 mode=0, sel=3'd5 with N=5, SEL_W=3 -> in_ready all zero, out_valid stays 0.
REQ-038 rst asserted mid-stream with out_valid=1 -> out_valid=0 before the next clock edge; after release, round-robin restarts at ch0; with the parity macro defined, word 8'h07 gives out_parity=1.
